// File: rtl/cluster_rotate_ctrl_pkg.sv
// Shared definitions for the cluster mask rotation scheduler. The `define block
// mirrors DTEngine_defines.vh so job-control status readback can decode state codes.
`ifndef NUM_DTPU_CLUSTERS
`define NUM_DTPU_CLUSTERS 8
`endif
`ifndef CRC_ST_IDLE
`define CRC_ST_IDLE    3'd0
`define CRC_ST_ISSUE   3'd1
`define CRC_ST_WAIT    3'd2
`define CRC_ST_ROTATE  3'd3
`define CRC_ST_CAPTURE 3'd4
`define CRC_ST_DONE    3'd5
`endif

package cluster_rotate_ctrl_pkg;

    localparam int NUM_DTPU_CLUSTERS = `NUM_DTPU_CLUSTERS;

    typedef enum logic [2:0] {
        ST_IDLE    = `CRC_ST_IDLE,
        ST_ISSUE   = `CRC_ST_ISSUE,
        ST_WAIT    = `CRC_ST_WAIT,
        ST_ROTATE  = `CRC_ST_ROTATE,
        ST_CAPTURE = `CRC_ST_CAPTURE,
        ST_DONE    = `CRC_ST_DONE
    } state_e;

    // Unsupported rotate amounts collapse to 0 so the mask is reissued unchanged.
    function automatic int unsigned legal_step(int unsigned step, int unsigned num_clusters);
        if (step == 1 || step == 2 || (step == 4 && num_clusters == 8)) begin
            return step;
        end
        return 0;
    endfunction

endpackage

// File: rtl/cluster_rotate_ctrl_if.sv
// Job-control and dispatch signals of the cluster rotation scheduler.
// master = job control / dispatch side, slave = the scheduler.
interface cluster_rotate_ctrl_if
    import cluster_rotate_ctrl_pkg::*;
#(
    parameter int NUM_CLUSTERS = NUM_DTPU_CLUSTERS,
    parameter int CLUSTER_BITS = 3,
    parameter int ROUND_BITS   = 16
);
    logic                    start;
    logic [NUM_CLUSTERS-1:0] start_mask;
    logic [CLUSTER_BITS-1:0] step;
    logic [ROUND_BITS-1:0]   num_rounds;
    logic                    abort;
    logic                    mask_ready;
    logic                    round_done;
    logic [NUM_CLUSTERS-1:0] mask_out;
    logic                    mask_valid;
    logic [ROUND_BITS-1:0]   round_idx;
    logic                    busy;
    logic                    done;

    modport master (
        output start, start_mask, step, num_rounds, abort, mask_ready, round_done,
        input  mask_out, mask_valid, round_idx, busy, done
    );

    modport slave (
        input  start, start_mask, step, num_rounds, abort, mask_ready, round_done,
        output mask_out, mask_valid, round_idx, busy, done
    );
endinterface

// File: rtl/cluster_rotate_ctrl_rls.sv
// RLS: registered circular left rotator, one cycle latency; holds its output
// while shift_enable is low.
module RLS
    import cluster_rotate_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = NUM_DTPU_CLUSTERS,
    parameter int DATA_WIDTH_BITS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       shift_enable,
    input  logic [DATA_WIDTH_BITS-1:0] shift_count,
    output logic [DATA_WIDTH-1:0]      data_out
);
    logic [2*DATA_WIDTH-1:0] doubled;

    assign doubled = {data_in, data_in} << shift_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (shift_enable) begin
            data_out <= doubled[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end
endmodule

// File: rtl/cluster_rotate_ctrl.sv
// Round scheduler: offers the current cluster mask to dispatch, waits for round
// completion, and rotates the mask through an RLS instance between rounds.
module cluster_rotate_ctrl
    import cluster_rotate_ctrl_pkg::*;
#(
    parameter int NUM_CLUSTERS = NUM_DTPU_CLUSTERS,
    parameter int CLUSTER_BITS = 3,
    parameter int ROUND_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cluster_rotate_ctrl_if.slave bus
);
    state_e                  state_q, state_d;
    logic [NUM_CLUSTERS-1:0] cur_mask_q, cur_mask_d;
    logic [CLUSTER_BITS-1:0] step_q, step_d;
    logic [ROUND_BITS-1:0]   nrounds_q, nrounds_d;
    logic [ROUND_BITS-1:0]   round_q, round_d;

    logic                    rot_en;
    logic [NUM_CLUSTERS-1:0] rot_data;
    logic [CLUSTER_BITS-1:0] rot_cnt;
    logic [NUM_CLUSTERS-1:0] rot_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_mask_q <= '0;
            step_q     <= '0;
            nrounds_q  <= '0;
            round_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_mask_q <= cur_mask_d;
            step_q     <= step_d;
            nrounds_q  <= nrounds_d;
            round_q    <= round_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_mask_d = cur_mask_q;
        step_d     = step_q;
        nrounds_d  = nrounds_q;
        round_d    = round_q;
        // Abort keeps mask/round registers so the last offer stays observable.
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        cur_mask_d = bus.start_mask;
                        step_d     = CLUSTER_BITS'(legal_step(32'(bus.step), NUM_CLUSTERS));
                        nrounds_d  = bus.num_rounds;
                        round_d    = '0;
                        state_d    = (bus.num_rounds == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mask_ready) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.round_done) begin
                        state_d = (round_q == nrounds_q - ROUND_BITS'(1)) ? ST_DONE : ST_ROTATE;
                    end
                end
                ST_ROTATE:  state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    cur_mask_d = rot_out;
                    round_d    = round_q + ROUND_BITS'(1);
                    state_d    = ST_ISSUE;
                end
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    assign rot_en   = (state_q == ST_ROTATE);
    assign rot_data = rot_en ? cur_mask_q : '0;
    assign rot_cnt  = rot_en ? step_q : '0;

    RLS #(
        .DATA_WIDTH      (NUM_CLUSTERS),
        .DATA_WIDTH_BITS (CLUSTER_BITS)
    ) u_rls (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (rot_data),
        .shift_enable (rot_en),
        .shift_count  (rot_cnt),
        .data_out     (rot_out)
    );

    assign bus.mask_out   = cur_mask_q;
    assign bus.mask_valid = (state_q == ST_ISSUE);
    assign bus.round_idx  = round_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
endmodule

// File: doc/cluster_rotate_ctrl.md
# cluster_rotate_ctrl

Round scheduler that drives the DTPU-cluster mask rotator. It accepts a job (initial cluster mask, rotation step, round count) and publishes the current mask to the cluster dispatch logic with a valid/ready handshake. It then waits for the clusters to report round completion and rotates the mask through its rotator instance before issuing the next round. It sits between the engine's job-control register block and the per-cluster dispatch logic.

## Interface
- `NUM_CLUSTERS`, default `NUM_DTPU_CLUSTERS` (8): mask width. Legal values are 4 and 8.
- `CLUSTER_BITS`, default 3: width of `step`. It is 3 for 8 clusters and 2 for 4 clusters.
- `ROUND_BITS`, default 16: width of the round counter.
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  job start pulse. Sampled only in IDLE.
- `start_mask`  in  NUM_CLUSTERS  initial cluster mask. Captured with `start`.
- `step`  in  CLUSTER_BITS  left-rotate amount. Captured with `start`.
- `num_rounds`  in  ROUND_BITS  number of rounds. Captured with `start`.
- `abort`  in  1  cancels the job from any state.
- `mask_ready`  in  1  dispatch accepts the mask.
- `round_done`  in  1  single-cycle pulse: all clusters have finished the current round.
- `mask_out`  out  NUM_CLUSTERS  current round's mask.
- `mask_valid`  out  1  `mask_out` is offered to dispatch.
- `round_idx`  out  ROUND_BITS  zero-based index of the current round.
- `busy`  out  1  asserted in every state except IDLE.
- `done`  out  1  one-cycle pulse at normal job completion.

## Operation
- States: IDLE, ISSUE, WAIT, ROTATE, CAPTURE, DONE.
- IDLE:
  - On `start`, capture `start_mask`, `step` and `num_rounds`, and clear `round_idx`.
  - Go to DONE if `num_rounds`==0, otherwise go to ISSUE.
  - `cur_mask` is loaded with `start_mask`.
- ISSUE: hold `mask_valid`=1 with `mask_out` stable until `mask_ready`=1, then go to WAIT.
- WAIT:
  - Wait for `round_done`.
  - If `round_idx`==`num_rounds`-1, go to DONE. Otherwise go to ROTATE.
- ROTATE: drive the rotator with `data_in`=`cur_mask`, `shift_enable`=1 and `shift_count`=captured step.
- CAPTURE: `cur_mask` takes the rotator output, `round_idx` increments, then go to ISSUE.
- DONE: pulse `done` for one cycle, then go to IDLE.
- Legal step values are 1, 2 and 4; 4 is legal only when `NUM_CLUSTERS`=8. Step 0 and any illegal step rotate by 0, so the mask is unchanged. Rounds still execute normally.
- Rotation is circular: bits shifted out of the MSB wrap into the LSB.
- `round_done` is ignored outside WAIT, including when it coincides with the ISSUE handshake.
- `start` is ignored while `busy`=1.
- `abort`:
  - Has priority over every other input.
  - Sends any state to IDLE on the next edge.
  - Clears `mask_valid` and produces no `done` pulse.
  - Leaves `mask_out` and `round_idx` holding their last values.
- Reset values: every output is 0 (`mask_out`, `mask_valid`, `round_idx`, `busy`, `done`). The state is IDLE, `cur_mask` is 0, and the rotator inputs are 0 with `shift_enable`=0.

## Timing
- Start to first offer: `start` at cycle T gives `mask_valid`=1 at T+1.
- Empty job: `num_rounds`=0 gives `done`=1 at T+1 and `busy`=0 at T+2.
- Handshake: it completes in the cycle where `mask_valid`&&`mask_ready`. `mask_valid` is 0 in the following cycle.
- Round-to-round: `round_done` at cycle W gives ROTATE at W+1, CAPTURE at W+2 and ISSUE at W+3. The new `mask_out`, `round_idx` and `mask_valid` are all visible at W+3.
- Last round: `round_done` at cycle W gives `done` at W+1, `busy`=0 at W+2, and a new `start` is accepted at W+2.
- The rotator is registered with 1-cycle latency. CAPTURE samples its output exactly one cycle after ROTATE.
- `mask_out` must not change while `mask_valid`=1.

## Structure
- `NUM_DTPU_CLUSTERS` comes from the shared `DTEngine_defines.vh` header.
- The state encodings are added to that header as `define constants, so that job-control status readback can decode them.
- Sub-module: one instance of the existing `RLS` rotator, with `DATA_WIDTH`=`NUM_CLUSTERS` and `DATA_WIDTH_BITS`=`CLUSTER_BITS`. The controller does no rotation itself.
- The controller is a single FSM plus the `cur_mask` register and the round counter.

## Test plan
- 8 clusters, mask 8'h03, step 1, 3 rounds, `mask_ready` tied high, `round_done` 5 cycles after each handshake → masks 03, 06, 0C with `round_idx` 0, 1, 2, then one `done` pulse.
- Wrap-around: mask 8'hC0, step 2, 2 rounds → 8'hC0 then 8'h03. Mask 8'h0F, step 4 → 8'h0F then 8'hF0.
- Illegal step 3, mask 8'h81, 3 rounds → 8'h81 issued every round, `done` asserted.
- Backpressure: hold `mask_ready` low for 6 cycles and pulse `round_done` during ISSUE → `mask_out` stays stable, the early `round_done` is ignored, and the round completes only on a `round_done` seen in WAIT.
- `num_rounds`=0 → `done` at T+1, `mask_valid` never asserted. A `start` while busy is ignored.
- `abort` during WAIT in round 1, and `rst_n` low during CAPTURE → next cycle IDLE with `mask_valid`=0 and no `done` pulse. After reset all outputs are 0, and a fresh job runs correctly.
